uart_frame_receiver: RTL and testbench

Receive-side counterpart of the camera frame transmit path. The block deserialises 8N1 UART bytes arriving on `i_RX` and writes each byte into a frame buffer RAM through a single write port (address, data, enable). When a full frame of `BYTES_PER_FRAME` bytes has been written, it signals completion. It lets a host push an image or lookup frame into the same RAM20k-style buffer the transmit path reads from.

---
 rtl/uart_frame_receiver_pkg.sv | 17 +
 rtl/uart_frame_receiver_if.sv | 38 +++
 rtl/uart_frame_receiver_rx_byte.sv | 122 ++++++++++++
 rtl/uart_frame_receiver.sv | 119 +++++++++++
 tb/tb_uart_frame_receiver.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_receiver_pkg.sv
// Shared UART frame constants and byte FSM state encoding.
// Both the transmit and receive frame paths use these definitions.
package uart_frame_receiver_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT    = 32'd1085;
    localparam int unsigned DEF_BYTES_PER_FRAME = 32'd6144;
    localparam int unsigned DEF_ADDR_WIDTH      = 32'd15;
    localparam int unsigned DEF_TIMEOUT_CLKS    = 32'd625010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Serial input and frame buffer write port of the UART frame receiver.
// slave: the receiver itself; master: the host/RAM side.
interface uart_frame_receiver_if
    import uart_frame_receiver_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  i_RX;
    logic                  i_Enable;
    logic [7:0]            o_Wr_Data;
    logic [ADDR_WIDTH-1:0] o_Wr_Addr;
    logic                  o_Wr_En;
    logic                  o_Frame_Done;
    logic                  o_Frame_Error;
    logic                  o_Busy;

    modport slave (
        input  i_RX,
        input  i_Enable,
        output o_Wr_Data,
        output o_Wr_Addr,
        output o_Wr_En,
        output o_Frame_Done,
        output o_Frame_Error,
        output o_Busy
    );

    modport master (
        output i_RX,
        output i_Enable,
        input  o_Wr_Data,
        input  o_Wr_Addr,
        input  o_Wr_En,
        input  o_Frame_Done,
        input  o_Frame_Error,
        input  o_Busy
    );
endinterface

// File: rtl/uart_frame_receiver_rx_byte.sv
// 8N1 UART byte receiver: 2-flop RX synchroniser plus IDLE/START/DATA/STOP FSM.
// byte_valid and frame_err are single-cycle strobes decoded at the stop-bit
// sample; rx_byte is stable while they are asserted.
module uart_rx_byte
    import uart_frame_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       Clk,
    input  logic       i_Rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output rx_state_e  state
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 32'd2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);

    logic             sync1_r, sync2_r;
    rx_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             byte_valid_s, frame_err_s;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Byte FSM state, bit-timing counter, bit index and shift register.
    always_ff @(posedge Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

    // Next-state logic: mid-bit start check, end-of-bit data/stop sampling.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        bit_idx_s    = bit_idx_r;
        shift_s      = shift_r;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (!sync2_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_s     = '0;
                    bit_idx_s = 3'd0;
                    if (!sync2_r) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    shift_s = {sync2_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    state_s = ST_IDLE;
                    if (sync2_r) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    assign rx_byte    = shift_r;
    assign byte_valid = byte_valid_s;
    assign frame_err  = frame_err_s;
    assign state      = state_r;

endmodule

// File: rtl/uart_frame_receiver.sv
// UART frame receiver: writes each received byte into a frame buffer RAM,
// pulses o_Frame_Done after the last byte of a frame, o_Frame_Error on a
// framing error. Optional mid-frame idle timeout: define UART_FRAME_TIMEOUT_EN.
module uart_frame_receiver
    import uart_frame_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = DEF_CLKS_PER_BIT,
    parameter int unsigned BYTES_PER_FRAME = DEF_BYTES_PER_FRAME,
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CLKS    = DEF_TIMEOUT_CLKS
) (
    input logic                  Clk,
    input logic                  i_Rst,
    uart_frame_receiver_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BYTES_PER_FRAME - 32'd1);

    logic [7:0]            rx_byte_s;
    logic                  byte_valid_s;
    logic                  frame_err_s;
    rx_state_e             rx_state_s;
    logic                  timeout_hit_s;

    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [7:0]            wr_data_r, wr_data_s;
    logic                  wr_en_r, wr_en_s;
    logic                  done_r, done_s;
    logic                  err_r, err_s;
    logic                  busy_r, busy_s;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .Clk        (Clk),
        .i_Rst      (i_Rst),
        .rx         (bus.i_RX),
        .rx_byte    (rx_byte_s),
        .byte_valid (byte_valid_s),
        .frame_err  (frame_err_s),
        .state      (rx_state_s)
    );

`ifdef UART_FRAME_TIMEOUT_EN
    logic [31:0] idle_cnt_r;

    // Idle counter: runs only with a partial frame pending and the line idle.
    always_ff @(posedge Clk or posedge i_Rst) begin
        if (i_Rst) begin
            idle_cnt_r <= 32'd0;
        end else if ((rx_state_s != ST_IDLE) || (addr_r == '0) || timeout_hit_s) begin
            idle_cnt_r <= 32'd0;
        end else begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
        end
    end

    assign timeout_hit_s = (rx_state_s == ST_IDLE) && (addr_r != '0) &&
                           (idle_cnt_r == (TIMEOUT_CLKS - 32'd1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Writer: strobe, address advance/wrap, done and error pulses, busy flag.
    always_comb begin
        wr_data_s = wr_data_r;
        wr_en_s   = 1'b0;
        if (byte_valid_s && bus.i_Enable) begin
            wr_en_s   = 1'b1;
            wr_data_s = rx_byte_s;
        end else begin
            wr_en_s   = 1'b0;
        end

        done_s = wr_en_r && (addr_r == LAST_ADDR);
        err_s  = frame_err_s || timeout_hit_s;

        // Error, timeout and enable drop all abandon the frame in progress.
        if (err_s || !bus.i_Enable) begin
            addr_s = '0;
        end else if (wr_en_r) begin
            if (addr_r == LAST_ADDR) begin
                addr_s = '0;
            end else begin
                addr_s = addr_r + ADDR_WIDTH'(1);
            end
        end else begin
            addr_s = addr_r;
        end

        busy_s = (rx_state_s != ST_IDLE) || (addr_r != '0);
    end

    // Output and address registers.
    always_ff @(posedge Clk or posedge i_Rst) begin
        if (i_Rst) begin
            addr_r    <= '0;
            wr_data_r <= 8'h00;
            wr_en_r   <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            addr_r    <= addr_s;
            wr_data_r <= wr_data_s;
            wr_en_r   <= wr_en_s;
            done_r    <= done_s;
            err_r     <= err_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.o_Wr_Data     = wr_data_r;
    assign bus.o_Wr_Addr     = addr_r;
    assign bus.o_Wr_En       = wr_en_r;
    assign bus.o_Frame_Done  = done_r;
    assign bus.o_Frame_Error = err_r;
    assign bus.o_Busy        = busy_r;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Scoreboard bench for uart_frame_receiver with scaled-down parameters.
module tb_uart_frame_receiver;

    localparam int CPB = 16;
    localparam int BPF = 128;
    localparam int AW  = 7;
    localparam int TO  = 400;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic Clk;
    logic i_Rst;

    uart_frame_receiver_if #(.ADDR_WIDTH(AW)) bus ();

    uart_frame_receiver #(
        .CLKS_PER_BIT    (CPB),
        .BYTES_PER_FRAME (BPF),
        .ADDR_WIDTH      (AW),
        .TIMEOUT_CLKS    (TO)
    ) dut (
        .Clk   (Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    wr_t       exp_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = 0;
    int        last_wr_cyc = 0;
    bit        have_prev = 1'b0;
    int        wr_cnt   = 0;
    int        done_cnt = 0;
    int        err_cnt  = 0;
    int        exp_done = 0;
    int        exp_err  = 0;
    logic [AW-1:0] exp_addr = '0;
    int        t0;
    int        wr_before;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compare writes, count done/error pulses.
    always @(negedge Clk) begin
        wr_t e;
        if (!i_Rst) begin
            if (bus.o_Wr_En) begin
                check_val("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("wr_addr", 32'(bus.o_Wr_Addr), 32'(e.addr));
                    check_val("wr_data", 32'(bus.o_Wr_Data), 32'(e.data));
                end
                if (have_prev) check_val("wr_gap", 32'((cyc - last_wr_cyc) >= CPB), 32'd1);
                last_wr_cyc = cyc;
                have_prev = 1'b1;
                wr_cnt++;
            end
            if (bus.o_Frame_Done) begin
                done_cnt++;
                check_val("done_after_wr", 32'(cyc - last_wr_cyc), 32'd1);
            end
            if (bus.o_Frame_Error) err_cnt++;
        end
    end

    task automatic send_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.i_RX = frame[i];
            repeat (CPB) @(negedge Clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_ok);
        wr_t e;
        if (!stop_ok) begin
            exp_err++;
            exp_addr = '0;
        end else if (bus.i_Enable) begin
            e.addr = exp_addr;
            e.data = d;
            exp_q.push_back(e);
            if (exp_addr == AW'(BPF - 1)) begin
                exp_addr = '0;
                exp_done++;
            end else begin
                exp_addr = exp_addr + AW'(1);
            end
        end
        send_bits({stop_ok, d, 1'b0}, 10);
    endtask

    task automatic fill_to(input int target);
        while (int'(exp_addr) != target) send_byte(8'($urandom_range(0, 255)), 1'b1);
    endtask

    task automatic enable_pulse_low();
        bus.i_Enable = 1'b0;
        exp_addr = '0;
        repeat (2) @(negedge Clk);
        check_val("en_drop_addr", 32'(bus.o_Wr_Addr), 32'd0);
        bus.i_Enable = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_Rst        = 1'b1;
        bus.i_RX     = 1'b1;
        bus.i_Enable = 1'b0;
        repeat (3) @(negedge Clk);
        check_val("rst_wr_en",   32'(bus.o_Wr_En),       32'd0);
        check_val("rst_done",    32'(bus.o_Frame_Done),  32'd0);
        check_val("rst_err",     32'(bus.o_Frame_Error), 32'd0);
        check_val("rst_busy",    32'(bus.o_Busy),        32'd0);
        check_val("rst_wr_data", 32'(bus.o_Wr_Data),     32'd0);
        check_val("rst_wr_addr", 32'(bus.o_Wr_Addr),     32'd0);
        i_Rst = 1'b0;
        bus.i_Enable = 1'b1;
        repeat (3) @(negedge Clk);

        // Single byte and latency from the first low-sampling edge.
        t0 = cyc;
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge Clk);
        check_val("latency", 32'(last_wr_cyc - t0 - 1), 32'(LAT));
        check_val("single_wr_cnt", 32'(wr_cnt), 32'd1);
        enable_pulse_low();

        // Full frame with addr[7:0] pattern, then the next byte lands at 0.
        for (int i = 0; i < BPF; i++) send_byte(8'(i), 1'b1);
        repeat (3) @(negedge Clk);
        check_val("frame_done_cnt", 32'(done_cnt), 32'(exp_done));
        check_val("frame_wrap_addr", 32'(bus.o_Wr_Addr), 32'd0);
        send_byte(8'h77, 1'b1);
        repeat (3) @(negedge Clk);

        // Start-bit glitch: no write, no error.
        wr_before = wr_cnt;
        bus.i_RX = 1'b0;
        repeat (5) @(negedge Clk);
        bus.i_RX = 1'b1;
        repeat (3 * CPB) @(negedge Clk);
        check_val("glitch_no_wr", 32'(wr_cnt), 32'(wr_before));
        check_val("glitch_no_err", 32'(err_cnt), 32'(exp_err));
        check_val("glitch_addr", 32'(bus.o_Wr_Addr), 32'(exp_addr));
        check_val("busy_mid_frame", 32'(bus.o_Busy), 32'd1);

        // Framing error at address 100.
        fill_to(100);
        send_byte(8'h3C, 1'b0);
        repeat (3) @(negedge Clk);
        check_val("ferr_cnt", 32'(err_cnt), 32'(exp_err));
        check_val("ferr_addr", 32'(bus.o_Wr_Addr), 32'd0);
        send_byte(8'hC3, 1'b1);

        // Enable drop at address 50, then bytes with enable low.
        fill_to(50);
        repeat (2) @(negedge Clk);
        bus.i_Enable = 1'b0;
        exp_addr = '0;
        repeat (2) @(negedge Clk);
        check_val("en50_addr", 32'(bus.o_Wr_Addr), 32'd0);
        wr_before = wr_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b1);
        repeat (3) @(negedge Clk);
        check_val("en_off_no_wr", 32'(wr_cnt), 32'(wr_before));
        bus.i_Enable = 1'b1;
        @(negedge Clk);

        // Reset during data bit 3.
        fill_to(3);
        send_bits({1'b1, 8'hFF, 1'b0}, 4);
        bus.i_RX = 1'b1;
        repeat (CPB / 2) @(negedge Clk);
        #2 i_Rst = 1'b1;
        #1;
        check_val("mrst_wr_en",   32'(bus.o_Wr_En),       32'd0);
        check_val("mrst_done",    32'(bus.o_Frame_Done),  32'd0);
        check_val("mrst_err",     32'(bus.o_Frame_Error), 32'd0);
        check_val("mrst_busy",    32'(bus.o_Busy),        32'd0);
        check_val("mrst_wr_data", 32'(bus.o_Wr_Data),     32'd0);
        check_val("mrst_wr_addr", 32'(bus.o_Wr_Addr),     32'd0);
        exp_addr = '0;
        repeat (2) @(negedge Clk);
        i_Rst = 1'b0;
        repeat (2) @(negedge Clk);
        send_byte(8'h5A, 1'b1);
        repeat (3) @(negedge Clk);

        // Mid-frame idle: timeout build abandons the frame, default waits.
        enable_pulse_low();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 1'b1);
        repeat (TO + 50) @(negedge Clk);
`ifdef UART_FRAME_TIMEOUT_EN
        exp_err++;
        exp_addr = '0;
`endif
        check_val("idle_err_cnt", 32'(err_cnt), 32'(exp_err));
        check_val("idle_addr", 32'(bus.o_Wr_Addr), 32'(exp_addr));

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        check_val("total_done", 32'(done_cnt), 32'(exp_done));
        check_val("total_err", 32'(err_cnt), 32'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
